// File: rtl/unified_memory_arbiter_if.sv
// Bundle of the fetch port (I*), data port (D*) and unified memory port (Mem*).
//   slave  : arbiter view (requests and MemReadData in; responses and Mem* strobes out)
//   master : environment view (core requesters plus memory model)
// Optional macro ARB_PERF_CNT_EN adds IStallCycles/DStallCycles.
interface unified_memory_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic          IReq;
    logic [AW-1:0] IAdr;
    logic [DW-1:0] IRdata;
    logic          IValid;

    logic          DReq;
    logic          DWe;
    logic [AW-1:0] DAdr;
    logic [DW-1:0] DWdata;
    logic [BW-1:0] DByteEn;
    logic [DW-1:0] DRdata;
    logic          DValid;

    logic          MemEn;
    logic          MemWrite;
    logic [AW-1:0] MemAdr;
    logic [DW-1:0] MemWriteData;
    logic [BW-1:0] MemByteEn;
    logic [DW-1:0] MemReadData;

`ifdef ARB_PERF_CNT_EN
    logic [31:0]   IStallCycles;
    logic [31:0]   DStallCycles;

    modport slave (
        input  IReq, IAdr, DReq, DWe, DAdr, DWdata, DByteEn, MemReadData,
        output IRdata, IValid, DRdata, DValid,
        output MemEn, MemWrite, MemAdr, MemWriteData, MemByteEn,
        output IStallCycles, DStallCycles
    );

    modport master (
        output IReq, IAdr, DReq, DWe, DAdr, DWdata, DByteEn, MemReadData,
        input  IRdata, IValid, DRdata, DValid,
        input  MemEn, MemWrite, MemAdr, MemWriteData, MemByteEn,
        input  IStallCycles, DStallCycles
    );
`else
    modport slave (
        input  IReq, IAdr, DReq, DWe, DAdr, DWdata, DByteEn, MemReadData,
        output IRdata, IValid, DRdata, DValid,
        output MemEn, MemWrite, MemAdr, MemWriteData, MemByteEn
    );

    modport master (
        output IReq, IAdr, DReq, DWe, DAdr, DWdata, DByteEn, MemReadData,
        input  IRdata, IValid, DRdata, DValid,
        input  MemEn, MemWrite, MemAdr, MemWriteData, MemByteEn
    );
`endif
endinterface

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported unified memory between instruction fetch (I) and
// data access (D). One transaction in flight, D has priority, and a starvation
// counter forces an I grant after STARVE_LIMIT consecutive D wins over a
// pending I. Each requester gets a one-cycle Valid pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    unified_memory_arbiter_if.slave (I*, D*, Mem* signals)
// Parameters: MEM_LATENCY (1-7), STARVE_LIMIT (1-15).
// Optional macro ARB_PERF_CNT_EN adds saturating IStallCycles/DStallCycles.
// IRdata/DRdata are gated combinational views of MemReadData because read
// data is only valid in the response cycle itself.
module unified_memory_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    unified_memory_arbiter_if.slave bus
);
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned BW       = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned STARVE_W = 4;
    localparam bit                  HAS_WAIT    = (MEM_LATENCY > 1);
    localparam logic [CNT_W-1:0]    WAIT_CYCLES = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                we_q,        we_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_write_q, mem_write_d;
    logic [AW-1:0]       mem_adr_q,   mem_adr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]       mem_be_q,    mem_be_d;
    logic                ivalid_q,    ivalid_d;
    logic                dvalid_q,    dvalid_d;

    // Next-state, arbitration and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_write_d = 1'b0;
        mem_adr_d   = '0;
        mem_wdata_d = '0;
        mem_be_d    = '0;
        ivalid_d    = 1'b0;
        dvalid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.IReq) begin
                    starve_d = '0;
                end
                // D wins unless I is pending and has hit the starvation limit
                if (bus.DReq && (!bus.IReq || (starve_q != STARVE_MAX))) begin
                    owner_d     = OWN_D;
                    we_d        = bus.DWe;
                    mem_en_d    = 1'b1;
                    mem_write_d = bus.DWe;
                    mem_adr_d   = bus.DAdr;
                    mem_wdata_d = bus.DWe ? bus.DWdata  : '0;
                    mem_be_d    = bus.DWe ? bus.DByteEn : '0;
                    if (bus.IReq) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    state_d     = ISSUE;
                end else if (bus.IReq) begin
                    owner_d   = OWN_I;
                    we_d      = 1'b0;
                    mem_en_d  = 1'b1;
                    mem_adr_d = bus.IAdr & ~AW'(3);
                    starve_d  = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!we_q && HAS_WAIT) begin
                    cnt_d   = WAIT_CYCLES;
                    state_d = WAIT;
                end else begin
                    ivalid_d = (owner_q == OWN_I);
                    dvalid_d = (owner_q == OWN_D);
                    state_d  = RESP;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    ivalid_d = (owner_q == OWN_I);
                    dvalid_d = (owner_q == OWN_D);
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_write_q <= mem_write_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign bus.MemEn        = mem_en_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemAdr       = mem_adr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.MemByteEn    = mem_be_q;
    assign bus.IValid       = ivalid_q;
    assign bus.DValid       = dvalid_q;
    assign bus.IRdata       = ivalid_q ? bus.MemReadData : '0;
    assign bus.DRdata       = (dvalid_q && !we_q) ? bus.MemReadData : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] istall_q, istall_d;
    logic [31:0] dstall_q, dstall_d;

    // Saturating counts of cycles spent requesting without a response
    always_comb begin
        istall_d = istall_q;
        dstall_d = dstall_q;
        if (bus.IReq && !ivalid_q && (istall_q != '1)) begin
            istall_d = istall_q + 32'd1;
        end
        if (bus.DReq && !dvalid_q && (dstall_q != '1)) begin
            dstall_d = dstall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            istall_q <= istall_d;
            dstall_q <= dstall_d;
        end
    end

    assign bus.IStallCycles = istall_q;
    assign bus.DStallCycles = dstall_q;
`endif
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed self-checking bench for unified_memory_arbiter.
// u_arb1 runs with MEM_LATENCY=1, u_arb3 with MEM_LATENCY=3; both STARVE_LIMIT=2.
// The memory model returns mem_word(addr) MEM_LATENCY cycles after a read
// MemEn and holds its last value otherwise.
module tb_unified_memory_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    unified_memory_arbiter_if bus1 ();
    unified_memory_arbiter_if bus3 ();

    unified_memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) u_arb1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    unified_memory_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(2)) u_arb3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return 32'hA500_0000 ^ a;
    endfunction

    logic [31:0] rd1 = '0;
    logic [31:0] rd3 = '0;
    logic [31:0] a0  = '0;
    logic [31:0] a1  = '0;
    logic        p0  = 1'b0;
    logic        p1  = 1'b0;

    always @(posedge clk) begin
        if (bus1.MemEn && !bus1.MemWrite) rd1 <= mem_word(bus1.MemAdr);
    end

    always @(posedge clk) begin
        p0 <= bus3.MemEn && !bus3.MemWrite;
        a0 <= bus3.MemAdr;
        p1 <= p0;
        a1 <= a0;
        if (p1) rd3 <= mem_word(a1);
    end

    assign bus1.MemReadData = rd1;
    assign bus3.MemReadData = rd3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.IReq = 1'b0; bus1.IAdr = '0; bus1.DReq = 1'b0; bus1.DWe = 1'b0;
        bus1.DAdr = '0;   bus1.DWdata = '0; bus1.DByteEn = '0;
        bus3.IReq = 1'b0; bus3.IAdr = '0; bus3.DReq = 1'b0; bus3.DWe = 1'b0;
        bus3.DAdr = '0;   bus3.DWdata = '0; bus3.DByteEn = '0;
    endtask

    task automatic test_reset();
        logic [135:0] o1, o3;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        o1 = {bus1.MemEn, bus1.MemWrite, bus1.MemAdr, bus1.MemWriteData, bus1.MemByteEn,
              bus1.IValid, bus1.DValid, bus1.IRdata, bus1.DRdata};
        o3 = {bus3.MemEn, bus3.MemWrite, bus3.MemAdr, bus3.MemWriteData, bus3.MemByteEn,
              bus3.IValid, bus3.DValid, bus3.IRdata, bus3.DRdata};
        checks++; if (o1 !== '0) begin errors++; $display("FAIL reset_outputs_lat1: got %h expected 0", o1); end
        checks++; if (o3 !== '0) begin errors++; $display("FAIL reset_outputs_lat3: got %h expected 0", o3); end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_ifetch();
        bus1.IReq = 1'b1; bus1.IAdr = 32'h0000_0006;
        tick();
        checks++; if ({bus1.MemEn, bus1.MemWrite, bus1.MemByteEn} !== 6'b10_0000) begin
            errors++; $display("FAIL ifetch_issue_ctrl: got %b expected 100000", {bus1.MemEn, bus1.MemWrite, bus1.MemByteEn}); end
        checks++; if (bus1.MemAdr !== 32'h4) begin errors++; $display("FAIL ifetch_memadr: got %h expected 00000004", bus1.MemAdr); end
        checks++; if (bus1.IValid !== 1'b0) begin errors++; $display("FAIL ifetch_early_valid: got %b expected 0", bus1.IValid); end
        tick();
        checks++; if ({bus1.IValid, bus1.DValid} !== 2'b10) begin errors++; $display("FAIL ifetch_valid: got %b expected 10", {bus1.IValid, bus1.DValid}); end
        checks++; if (bus1.IRdata !== 32'h0050_0093) begin errors++; $display("FAIL ifetch_rdata: got %h expected 00500093", bus1.IRdata); end
        bus1.IReq = 1'b0;
        tick();
        checks++; if ({bus1.IValid, bus1.IRdata} !== 33'd0) begin errors++; $display("FAIL ifetch_after: got %b/%h expected 0/0", bus1.IValid, bus1.IRdata); end
        tick();
    endtask

    task automatic test_dwrite();
        bus1.DReq = 1'b1; bus1.DWe = 1'b1; bus1.DAdr = 32'hC; bus1.DWdata = 32'h0F; bus1.DByteEn = 4'hF;
        tick();
        checks++; if ({bus1.MemEn, bus1.MemWrite, bus1.MemByteEn} !== 6'b11_1111) begin
            errors++; $display("FAIL dwrite_issue_ctrl: got %b expected 111111", {bus1.MemEn, bus1.MemWrite, bus1.MemByteEn}); end
        checks++; if ({bus1.MemAdr, bus1.MemWriteData} !== {32'hC, 32'h0F}) begin
            errors++; $display("FAIL dwrite_adr_data: got %h/%h expected 0000000c/0000000f", bus1.MemAdr, bus1.MemWriteData); end
        tick();
        checks++; if ({bus1.DValid, bus1.IValid, bus1.MemEn} !== 3'b100) begin
            errors++; $display("FAIL dwrite_valid: got %b expected 100", {bus1.DValid, bus1.IValid, bus1.MemEn}); end
        checks++; if (bus1.DRdata !== 32'h0) begin errors++; $display("FAIL dwrite_rdata: got %h expected 0", bus1.DRdata); end
        bus1.DReq = 1'b0; bus1.DWe = 1'b0;
        tick();
        checks++; if ({bus1.DValid, bus1.MemEn} !== 2'b00) begin errors++; $display("FAIL dwrite_after: got %b expected 00", {bus1.DValid, bus1.MemEn}); end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_d [6];
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus1.IReq = 1'b1; bus1.IAdr = 32'h100;
        bus1.DReq = 1'b1; bus1.DWe = 1'b0; bus1.DAdr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            while (!(bus1.IValid || bus1.DValid) && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 10) begin
                errors++; $display("FAIL starve_timeout txn %0d: no Valid within 10 cycles", k);
            end else if ({bus1.DValid, bus1.IValid} !== {exp_d[k], ~exp_d[k]}) begin
                errors++; $display("FAIL starve_order txn %0d: got D/I %b%b expected %b%b", k,
                                   bus1.DValid, bus1.IValid, exp_d[k], ~exp_d[k]);
            end
            checks++;
            if (exp_d[k] && bus1.DRdata !== 32'hA500_0200) begin
                errors++; $display("FAIL starve_ddata txn %0d: got %h expected a5000200", k, bus1.DRdata);
            end else if (!exp_d[k] && bus1.IRdata !== 32'hA500_0100) begin
                errors++; $display("FAIL starve_idata txn %0d: got %h expected a5000100", k, bus1.IRdata);
            end
            tick();
        end
        bus1.IReq = 1'b0; bus1.DReq = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_latency3();
        logic [2:0] exp_v;
        bus3.DReq = 1'b1; bus3.DWe = 1'b0; bus3.DAdr = 32'h10;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            exp_v = {(cyc == 1 || cyc == 6), (cyc == 4), (cyc == 9)};
            checks++;
            if ({bus3.MemEn, bus3.DValid, bus3.IValid} !== exp_v) begin
                errors++; $display("FAIL lat3_cycle%0d: got MemEn/DValid/IValid %b expected %b", cyc,
                                   {bus3.MemEn, bus3.DValid, bus3.IValid}, exp_v);
            end
            if (cyc == 1) begin
                checks++; if (bus3.MemAdr !== 32'h10) begin errors++; $display("FAIL lat3_dadr: got %h expected 00000010", bus3.MemAdr); end
            end
            if (cyc == 3) begin
                checks++; if (bus3.DRdata !== 32'h0) begin errors++; $display("FAIL lat3_rdata_gate: got %h expected 0", bus3.DRdata); end
            end
            if (cyc == 4) begin
                checks++; if (bus3.DRdata !== 32'hA500_0010) begin errors++; $display("FAIL lat3_ddata: got %h expected a5000010", bus3.DRdata); end
            end
            if (cyc == 6) begin
                checks++; if (bus3.MemAdr !== 32'h20) begin errors++; $display("FAIL lat3_iadr: got %h expected 00000020", bus3.MemAdr); end
            end
            if (cyc == 9) begin
                checks++; if (bus3.IRdata !== 32'hA500_0020) begin errors++; $display("FAIL lat3_idata: got %h expected a5000020", bus3.IRdata); end
            end
            if (cyc == 2) begin bus3.IReq = 1'b1; bus3.IAdr = 32'h20; end
            if (cyc == 4) bus3.DReq = 1'b0;
            if (cyc == 9) bus3.IReq = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [135:0] o3;
        logic         saw;
        bus3.DReq = 1'b1; bus3.DWe = 1'b0; bus3.DAdr = 32'h30;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        o3 = {bus3.MemEn, bus3.MemWrite, bus3.MemAdr, bus3.MemWriteData, bus3.MemByteEn,
              bus3.IValid, bus3.DValid, bus3.IRdata, bus3.DRdata};
        checks++; if (o3 !== '0) begin errors++; $display("FAIL rst_wait_outputs: got %h expected 0", o3); end
        bus3.DReq = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus3.DValid) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_dropped_valid: got %b expected 0", saw); end
        bus3.DReq = 1'b1; bus3.DAdr = 32'h40;
        repeat (4) tick();
        checks++; if ({bus3.DValid, bus3.DRdata} !== {1'b1, 32'hA500_0040}) begin
            errors++; $display("FAIL rst_next_req: got %b/%h expected 1/a5000040", bus3.DValid, bus3.DRdata); end
        bus3.DReq = 1'b0;
        tick();
        tick();
        bus3.DReq = 1'b1; bus3.DAdr = 32'h50;
        tick();
        checks++; if (bus3.MemEn !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: got MemEn %b expected 1", bus3.MemEn); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus3.MemEn, bus3.MemAdr} !== 33'd0) begin
            errors++; $display("FAIL rst_async_issue: got %b/%h expected 0/0", bus3.MemEn, bus3.MemAdr); end
        bus3.DReq = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        int ic = 0;
        int dc = 0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        bus1.IReq = 1'b1; bus1.IAdr = 32'h100;
        bus1.DReq = 1'b1; bus1.DWe = 1'b0; bus1.DAdr = 32'h200;
        for (int i = 0; i < 18; i++) begin
            if (bus1.IReq && !bus1.IValid) ic++;
            if (bus1.DReq && !bus1.DValid) dc++;
            tick();
        end
        bus1.IReq = 1'b0; bus1.DReq = 1'b0;
        tick();
        checks++; if (bus1.IStallCycles !== 32'(ic)) begin
            errors++; $display("FAIL perf_istall: got %0d expected %0d", bus1.IStallCycles, ic); end
        checks++; if (bus1.DStallCycles !== 32'(dc)) begin
            errors++; $display("FAIL perf_dstall: got %0d expected %0d", bus1.DStallCycles, dc); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ifetch();
        test_dwrite();
        test_starvation();
        test_latency3();
        test_reset_mid();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
